// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator with a DEPTH-stage valid/ready pipeline.
// Decode and sign extension happen before stage 1; stages carry {valid, imm, fmt}.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_lui
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;

   logic [2:0]      dec_fmt;
   logic [31:0]     dec_imm32;
   logic [XLEN-1:0] dec_imm;

   logic            valid_reg [DEPTH];
   logic [XLEN-1:0] imm_reg   [DEPTH];
   logic [2:0]      fmt_reg   [DEPTH];
   logic            flush_hold_reg;
   logic [XLEN-1:0] lui_reg;

   logic            stage_rdy [DEPTH];
   logic            src_valid [DEPTH];
   logic [XLEN-1:0] src_imm   [DEPTH];
   logic [2:0]      src_fmt   [DEPTH];

   always_comb begin
      dec_fmt   = FMT_NONE;
      dec_imm32 = '0;
      case (in_inst[6:0])
         7'b0000011, 7'b0001111, 7'b0010011,
         7'b0011011, 7'b1100111, 7'b1110011: begin
            dec_fmt   = FMT_I;
            dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         7'b0100011: begin
            dec_fmt   = FMT_S;
            dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         7'b1100011: begin
            dec_fmt   = FMT_B;
            dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                         in_inst[30:25], in_inst[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt   = FMT_U;
            dec_imm32 = {in_inst[31:12], 12'h000};
         end
         7'b1101111: begin
            dec_fmt   = FMT_J;
            dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                         in_inst[20], in_inst[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   assign dec_imm = XLEN'($signed(dec_imm32));

   // A stage may load when it is empty or its occupant moves on; walk from the output back.
   always_comb begin
      logic rdy;
      rdy = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         rdy          = !valid_reg[k] || rdy;
         stage_rdy[k] = rdy;
      end
   end

   assign in_ready = stage_rdy[0] && !flush && !flush_hold_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
         if (gi == 0) begin : g_head
            assign src_valid[gi] = in_valid && in_ready;
            assign src_imm[gi]   = dec_imm;
            assign src_fmt[gi]   = dec_fmt;
         end else begin : g_tail
            assign src_valid[gi] = valid_reg[gi-1];
            assign src_imm[gi]   = imm_reg[gi-1];
            assign src_fmt[gi]   = fmt_reg[gi-1];
         end
      end
   endgenerate

   // Payload only moves with a valid entry, so bubbles and flushes leave out_imm/out_fmt untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_reg[k] <= 1'b0;
            imm_reg[k]   <= '0;
            fmt_reg[k]   <= FMT_NONE;
         end
         flush_hold_reg <= 1'b0;
         lui_reg        <= '0;
      end else if (flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_reg[k] <= 1'b0;
         end
         flush_hold_reg <= 1'b1;
      end else begin
         flush_hold_reg <= 1'b0;
         if (valid_reg[DEPTH-1] && out_ready) begin
            lui_reg <= imm_reg[DEPTH-1];
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (stage_rdy[k]) begin
               valid_reg[k] <= src_valid[k];
               if (src_valid[k]) begin
                  imm_reg[k] <= src_imm[k];
                  fmt_reg[k] <= src_fmt[k];
               end
            end
         end
      end
   end

   assign out_valid = valid_reg[DEPTH-1];
   assign out_imm   = imm_reg[DEPTH-1];
   assign out_fmt   = fmt_reg[DEPTH-1];
   assign out_lui   = lui_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe against an in-order scoreboard
// whose immediates are computed arithmetically from the instruction fields.
module tb_imm_gen_pipe;

   localparam int XLEN  = 64;
   localparam int DEPTH = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_lui;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_fmt   (out_fmt),
      .out_lui   (out_lui)
   );

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
   } res_t;

   res_t            exp_q[$];
   logic [XLEN-1:0] mdl_lui;
   bit              mdl_hold;
   bit              last_acc;
   int              n_takes;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Field values weighted by bit position, minus the sign weight when the sign bit is set.
   function automatic res_t ref_decode(input logic [31:0] inst);
      res_t   r;
      longint v;
      longint sgn;
      sgn = inst[31] ? 1 : 0;
      v   = 0;
      r.fmt = 3'd0;
      case (inst[6:0])
         7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73: begin
            r.fmt = 3'd1;
            v = longint'(inst[31:20]) - sgn * 4096;
         end
         7'h23: begin
            r.fmt = 3'd2;
            v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]) - sgn * 4096;
         end
         7'h63: begin
            r.fmt = 3'd3;
            v = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                + longint'(inst[11:8]) * 2 - sgn * 4096;
         end
         7'h37, 7'h17: begin
            r.fmt = 3'd4;
            v = longint'(inst[31:12]) * 4096 - sgn * (64'sd1 << 32);
         end
         7'h6F: begin
            r.fmt = 3'd5;
            v = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                + longint'(inst[30:21]) * 2 - sgn * (64'sd1 << 20);
         end
         default: v = 0;
      endcase
      r.imm = v[XLEN-1:0];
      return r;
   endfunction

   // One clock: check pre-edge outputs against the model, take the edge, update the model.
   task automatic step();
      bit   acc;
      bit   take;
      res_t front;
      #1;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      check("out_lui", 64'(out_lui), 64'(mdl_lui));
      if (mdl_hold || flush) check("in_ready_blocked", 64'(in_ready), 64'd0);
      if (exp_q.size() == 0) begin
         check("no_phantom", 64'(out_valid), 64'd0);
         if (!mdl_hold && !flush) check("in_ready_empty", 64'(in_ready), 64'd1);
      end
      if (!out_ready && exp_q.size() == DEPTH) check("in_ready_full", 64'(in_ready), 64'd0);
      if (out_valid && exp_q.size() > 0) begin
         front = exp_q[0];
         check("out_imm", 64'(out_imm), 64'(front.imm));
         check("out_fmt", 64'(out_fmt), 64'(front.fmt));
      end
      @(posedge clk);
      last_acc = 1'b0;
      if (!rst_n) begin
         exp_q.delete();
         mdl_lui  = '0;
         mdl_hold = 1'b0;
      end else if (flush) begin
         exp_q.delete();
         mdl_hold = 1'b1;
      end else begin
         mdl_hold = 1'b0;
         if (take && exp_q.size() > 0) begin
            front   = exp_q.pop_front();
            mdl_lui = front.imm;
            n_takes++;
            $display("xfer out imm=%h fmt=%0d", front.imm, front.fmt);
         end
         if (acc) begin
            exp_q.push_back(ref_decode(in_inst));
            last_acc = 1'b1;
            $display("xfer in  inst=%h", in_inst);
         end
      end
      @(negedge clk);
   endtask

   // Single instruction into an empty pipeline; checks latency and the fixed expected value.
   task automatic send_one(input logic [31:0] inst, input logic [63:0] eimm, input logic [2:0] efmt);
      in_valid  = 1'b1;
      in_inst   = inst;
      out_ready = 1'b1;
      step();
      check("accepted", 64'(last_acc), 64'd1);
      in_valid = 1'b0;
      repeat (DEPTH - 1) begin
         #1;
         check("not_early", 64'(out_valid), 64'd0);
         step();
      end
      #1;
      check("latency_valid", 64'(out_valid), 64'd1);
      check("vec_imm", 64'(out_imm), eimm);
      check("vec_fmt", 64'(out_fmt), 64'(efmt));
      step();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [12];
      logic [31:0] r;
      int          sel;
      ops = '{7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
      r   = $urandom();
      sel = $urandom_range(12);
      if (sel == 12) return r;
      return {r[31:7], ops[sel]};
   endfunction

   initial begin
      logic [31:0]     vin  [7];
      logic [63:0]     vimm [7];
      logic [2:0]      vfmt [7];
      logic [XLEN-1:0] saved_imm;
      int              accepted;
      int              idx;
      int              budget;

      rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
      mdl_lui = '0; mdl_hold = 1'b0; last_acc = 1'b0; n_takes = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_imm",   64'(out_imm),   64'd0);
      check("rst_out_fmt",   64'(out_fmt),   64'd0);
      check("rst_out_lui",   64'(out_lui),   64'd0);

      vin[0] = 32'hFFF00093; vimm[0] = 64'hFFFFFFFFFFFFFFFF; vfmt[0] = 3'd1;
      vin[1] = 32'hFE20AE23; vimm[1] = 64'hFFFFFFFFFFFFFFFC; vfmt[1] = 3'd2;
      vin[2] = 32'hFE000CE3; vimm[2] = 64'hFFFFFFFFFFFFFFF8; vfmt[2] = 3'd3;
      vin[3] = 32'h001000EF; vimm[3] = 64'h0000000000000800; vfmt[3] = 3'd5;
      vin[4] = 32'h00000033; vimm[4] = 64'h0000000000000000; vfmt[4] = 3'd0;
      vin[5] = 32'h123452B7; vimm[5] = 64'h0000000012345000; vfmt[5] = 3'd4;
      vin[6] = 32'h800002B7; vimm[6] = 64'hFFFFFFFF80000000; vfmt[6] = 3'd4;
      for (int i = 0; i < 7; i++) send_one(vin[i], vimm[i], vfmt[i]);

      // Stall: five-instruction stream against a blocked output.
      out_ready = 1'b0;
      accepted  = 0;
      n_takes   = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid = (accepted < 5);
         in_inst  = rand_inst();
         step();
         if (last_acc) accepted++;
      end
      check("stall_accepted", 64'(accepted), 64'd3);
      out_ready = 1'b1;
      budget    = 0;
      while (n_takes < 5 && budget < 40) begin
         in_valid = (accepted < 5);
         in_inst  = rand_inst();
         step();
         if (last_acc) accepted++;
         budget++;
      end
      in_valid = 1'b0;
      check("drain_count", 64'(n_takes), 64'd5);
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      // Flush with two entries in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00500093; step();
      in_inst   = 32'h00A00113; step();
      in_valid  = 1'b0;
      step();
      saved_imm = out_imm;
      check("pre_flush_valid", 64'(out_valid), 64'd1);
      flush     = 1'b1; in_valid = 1'b1; in_inst = 32'h7FF00193; out_ready = 1'b1;
      step();
      flush = 1'b0;
      #1;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_hold_rdy",  64'(in_ready),  64'd0);
      check("flush_keep_imm",  64'(out_imm),   64'(saved_imm));
      step();
      #1;
      check("post_hold_rdy", 64'(in_ready), 64'd1);
      send_one(32'h00C00213, 64'd12, 3'd1);

      // Reset with the pipeline full.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      repeat (4) begin in_inst = rand_inst(); step(); end
      rst_n = 1'b0;
      step();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready",  64'(in_ready),  64'd1);
      check("mid_rst_out_imm",   64'(out_imm),   64'd0);
      check("mid_rst_out_fmt",   64'(out_fmt),   64'd0);
      check("mid_rst_out_lui",   64'(out_lui),   64'd0);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         idx       = $urandom_range(99);
         in_valid  = ($urandom_range(99) < 70);
         out_ready = ($urandom_range(99) < 70);
         flush     = (idx < 3);
         rst_n     = !(idx == 99);
         in_inst   = rand_inst();
         step();
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (DEPTH + 2) step();
      check("final_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 1, number of pipeline stages between input and output; legal range 1..4.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 Port in_valid  input  1  instruction on in_inst is valid.
REQ-006 Port in_ready  output  1  block accepts in_inst this cycle.
REQ-007 Port in_inst  input  32  full RV32 instruction word.
REQ-008 Port flush  input  1  discard all in-flight entries (pipeline bubble/nop).
REQ-009 Port out_valid  output  1  out_imm/out_fmt hold a valid result.
REQ-010 Port out_ready  input  1  downstream consumes result this cycle.
REQ-011 Port out_imm  output  XLEN  generated immediate, sign-extended to XLEN.
REQ-012 Port out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 6-7 unused.
REQ-013 Port out_lui  output  XLEN  immediate of the previous result taken at the output (out_valid & out_ready).

Function
REQ-014 Format SHALL be decoded from in_inst[6:0]: 0000011, 0001111, 0010011, 0011011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; any other -> NONE.
REQ-015 I: imm = sext(inst[31:20]).
REQ-016 S: imm = sext({inst[31:25], inst[11:7]}).
REQ-017 B: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
REQ-018 U: imm = sext({inst[31:12], 12'h000}); for XLEN=64 bits 63:32 replicate inst[31].
REQ-019 J: imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
REQ-020 NONE: imm = 0, fmt = 0, entry still propagates with valid set.
REQ-021 Decode and extension SHALL complete combinationally before stage 1; a result accepted at edge N SHALL be visible at the output after edge N+DEPTH-1 when no stall occurs.
REQ-022 Each stage holds {valid, imm, fmt}; stage k advances when stage k+1 is empty or advancing; last stage advances on out_ready.
REQ-023 in_ready = (stage 1 empty or advancing) and not flush and not flush_hold; transfer occurs only on in_valid & in_ready.
REQ-024 With out_ready low and all stages valid, in_ready SHALL be low and every stage content SHALL hold unchanged.
REQ-025 flush high SHALL clear every stage valid bit at the edge; input presented that cycle is discarded; out_imm/out_fmt keep last values, out_valid drops.
REQ-026 After a flush edge, flush_hold SHALL be set for exactly one cycle, forcing in_ready low; flush asserted during flush_hold re-arms the hold.
REQ-027 flush SHALL take priority over simultaneous input acceptance and output handshake; an output handshake in the flush cycle SHALL NOT update out_lui.
REQ-028 out_lui SHALL update to out_imm at each edge with out_valid & out_ready.
REQ-029 out_valid SHALL equal last-stage valid; out_imm/out_fmt SHALL be stable while out_valid & !out_ready.

Reset
REQ-030 rst_n low at an edge SHALL clear all stage valid bits, flush_hold, out_imm, out_fmt, out_lui to 0; in_ready is 1 the first cycle after rst_n high (out_valid 0).
REQ-031 Reset mid-operation SHALL discard in-flight entries with no output handshake.

Verification
REQ-032 XLEN=32, DEPTH=1: in_inst 0xFFF00093 (addi -1) -> out_imm 0xFFFFFFFF, fmt 1; 0xFE20AE23 (sw -4) -> 0xFFFFFFFC, fmt 2.
REQ-033 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt 3; 0x001000EF (jal +2048) -> 0x00000800, fmt 5; 0x00000033 (R-type) -> 0, fmt 0.
REQ-034 XLEN=64: 0x123452B7 -> 0x0000000012345000; 0x800002B7 -> 0xFFFFFFFF80000000, fmt 4.
REQ-035 DEPTH=3, out_ready low 10 cycles with stream of 5 instructions -> in_ready low after 3 accepted, outputs then drain in order with no loss or duplication; out_lui tracks prior result.
REQ-036 DEPTH=2, flush with 2 entries in flight -> out_valid 0 next cycle, in_ready 0 for one cycle then 1, next instruction emerges after 2 edges.
REQ-037 rst_n low for one edge with full pipeline -> all outputs 0, out_valid 0, in_ready 1 after release.
